// File: rtl/timer_multi.sv
// NCH independent up-counting timers sharing one tick: periodic/one-shot, sticky IRQ, threshold compare.
// Optional shared tick prescaler and presc port are enabled by defining TIMER_PRESCALER_EN.
module timer_multi #(
   parameter int NCH     = 4,
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       enable,
   input  logic [NCH-1:0]       mode,
   input  logic [NCH-1:0]       borra_irq,
   input  logic [NCH-1:0]       irq_mask,
   input  logic [NCH*WIDTH-1:0] fin_cuenta,
   input  logic [NCH*WIDTH-1:0] threshold,
`ifdef TIMER_PRESCALER_EN
   input  logic [PRESC_W-1:0]   presc,
`endif
   output logic [NCH*WIDTH-1:0] count,
   output logic [NCH-1:0]       irq,
   output logic                 irq_any,
   output logic [NCH-1:0]       out_th,
   output logic [NCH-1:0]       done
);

   logic tick;

`ifdef TIMER_PRESCALER_EN
   logic [PRESC_W-1:0] presc_cnt_reg;
   logic [PRESC_W-1:0] presc_cnt_next;

   // Free-running divider; it reloads on the cycle it matches presc.
   assign tick = (presc_cnt_reg == presc);

   always_comb begin
      presc_cnt_next = presc_cnt_reg + PRESC_W'(1);
      if (tick) begin
         presc_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt_reg <= '0;
      end else begin
         presc_cnt_reg <= presc_cnt_next;
      end
   end
`else
   // Without the prescaler every clock is a tick.
   assign tick = (PRESC_W > 0);
`endif

   assign irq_any = |(irq & irq_mask);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [WIDTH-1:0] cnt_reg;
         logic [WIDTH-1:0] cnt_next;
         logic             irq_reg;
         logic             irq_next;
         logic             done_reg;
         logic             done_next;
         logic             en_prev_reg;
         logic             counting;
         logic             terminal;
         logic             rearm;
         logic [WIDTH-1:0] fin_i;
         logic [WIDTH-1:0] th_i;

         assign fin_i    = fin_cuenta[gi*WIDTH +: WIDTH];
         assign th_i     = threshold[gi*WIDTH +: WIDTH];
         assign counting = enable[gi] & ~done_reg & tick;
         // >= keeps the count bounded when fin_cuenta drops below it mid-run.
         assign terminal = counting & (cnt_reg >= fin_i);
         assign rearm    = enable[gi] & ~en_prev_reg;

         always_comb begin
            cnt_next  = cnt_reg;
            irq_next  = irq_reg;
            done_next = done_reg;
            if (terminal) begin
               cnt_next = '0;
            end else if (counting) begin
               cnt_next = cnt_reg + WIDTH'(1);
            end
            // Terminal set takes priority over a simultaneous clear.
            if (terminal) begin
               irq_next = 1'b1;
            end else if (borra_irq[gi]) begin
               irq_next = 1'b0;
            end
            if (terminal && mode[gi]) begin
               done_next = 1'b1;
            end else if (rearm) begin
               done_next = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg     <= '0;
               irq_reg     <= 1'b0;
               done_reg    <= 1'b0;
               en_prev_reg <= 1'b0;
            end else begin
               cnt_reg     <= cnt_next;
               irq_reg     <= irq_next;
               done_reg    <= done_next;
               en_prev_reg <= enable[gi];
            end
         end

         assign count[gi*WIDTH +: WIDTH] = cnt_reg;
         assign irq[gi]                  = irq_reg;
         assign done[gi]                 = done_reg;
         assign out_th[gi]               = (cnt_reg > th_i);
      end
   endgenerate

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi; also exercises the prescaler when TIMER_PRESCALER_EN is defined.
module tb_timer_multi;
   localparam int NCH     = 4;
   localparam int WIDTH   = 32;
   localparam int PRESC_W = 16;
`ifdef TIMER_PRESCALER_EN
   localparam int DIV = 3;
`else
   localparam int DIV = 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH-1:0]       enable = '0;
   logic [NCH-1:0]       mode = '0;
   logic [NCH-1:0]       borra_irq = '0;
   logic [NCH-1:0]       irq_mask = '0;
   logic [NCH*WIDTH-1:0] fin_cuenta = '0;
   logic [NCH*WIDTH-1:0] threshold = '0;
`ifdef TIMER_PRESCALER_EN
   logic [PRESC_W-1:0]   presc = '0;
`endif
   logic [NCH*WIDTH-1:0] count;
   logic [NCH-1:0]       irq;
   logic                 irq_any;
   logic [NCH-1:0]       out_th;
   logic [NCH-1:0]       done;

   int n_checks = 0;
   int n_fail   = 0;

   timer_multi #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mode       (mode),
      .borra_irq  (borra_irq),
      .irq_mask   (irq_mask),
      .fin_cuenta (fin_cuenta),
      .threshold  (threshold),
`ifdef TIMER_PRESCALER_EN
      .presc      (presc),
`endif
      .count      (count),
      .irq        (irq),
      .irq_any    (irq_any),
      .out_th     (out_th),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] cnt_of(input int i);
      return count[i*WIDTH +: WIDTH];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      step(2);
      check("rst count",   {31'b0, |count}, 0);
      check("rst irq",     {28'b0, irq}, 0);
      check("rst done",    {28'b0, done}, 0);
      check("rst irq_any", {31'b0, irq_any}, 0);
      rst = 1'b0;

      // Channel 0 periodic, terminal 3
      fin_cuenta[0*WIDTH +: WIDTH] = 3;
      enable[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check($sformatf("t1 count0 k=%0d", k), cnt_of(0), k % 4);
         check($sformatf("t1 irq0 k=%0d", k), {31'b0, irq[0]}, (k >= 4) ? 1 : 0);
      end
      borra_irq[0] = 1'b1;
      step(1);
      check("t1 count0 after clr", cnt_of(0), 1);
      check("t1 irq0 cleared", {31'b0, irq[0]}, 0);
      borra_irq[0] = 1'b0;
      enable[0] = 1'b0;
      step(2);
      check("t1 count0 paused", cnt_of(0), 1);

      // Channel 1 one-shot, terminal 5, then re-arm
      mode[1] = 1'b1;
      fin_cuenta[1*WIDTH +: WIDTH] = 5;
      enable[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check($sformatf("t2 count1 k=%0d", k), cnt_of(1), k % 6);
         check($sformatf("t2 done1 k=%0d", k), {31'b0, done[1]}, (k == 6) ? 1 : 0);
      end
      check("t2 irq1", {31'b0, irq[1]}, 1);
      step(2);
      check("t2 count1 held", cnt_of(1), 0);
      check("t2 done1 held", {31'b0, done[1]}, 1);
      enable[1] = 1'b0;
      step(1);
      enable[1] = 1'b1;
      step(1);
      check("t2 done1 rearmed", {31'b0, done[1]}, 0);
      check("t2 count1 rearm", cnt_of(1), 0);
      step(1);
      check("t2 count1 restart", cnt_of(1), 1);
      enable[1] = 1'b0;
      borra_irq[1] = 1'b1;
      step(1);
      borra_irq[1] = 1'b0;
      check("t2 irq1 cleared", {31'b0, irq[1]}, 0);

      // Channel 2: clear held through terminal, set wins
      fin_cuenta[2*WIDTH +: WIDTH] = 2;
      borra_irq[2] = 1'b1;
      enable[2] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check($sformatf("t3 count2 k=%0d", k), cnt_of(2), k % 3);
         check($sformatf("t3 irq2 k=%0d", k), {31'b0, irq[2]}, (k == 3) ? 1 : 0);
      end
      enable[2] = 1'b0;
      borra_irq[2] = 1'b0;

      // Channel 3: threshold compare and masked irq_any
      fin_cuenta[3*WIDTH +: WIDTH] = 19;
      threshold[3*WIDTH +: WIDTH] = 10;
      irq_mask = 4'b0111;
      enable[3] = 1'b1;
      check("t4 out_th3 idle", {31'b0, out_th[3]}, 0);
      for (int k = 1; k <= 20; k++) begin
         step(1);
         check($sformatf("t4 count3 k=%0d", k), cnt_of(3), k % 20);
         check($sformatf("t4 out_th3 k=%0d", k), {31'b0, out_th[3]}, ((k % 20) > 10) ? 1 : 0);
      end
      check("t4 irq3", {31'b0, irq[3]}, 1);
      check("t4 irq_any masked", {31'b0, irq_any}, 0);
      irq_mask[3] = 1'b1;
      #1;
      check("t4 irq_any unmasked", {31'b0, irq_any}, 1);
      enable[3] = 1'b0;

      // Channel 0: lower terminal below running count, then terminal 0
      fin_cuenta[0*WIDTH +: WIDTH] = 100;
      enable[0] = 1'b1;
      step(49);
      check("t5 count0 at 50", cnt_of(0), 50);
      check("t5 irq0 before", {31'b0, irq[0]}, 0);
      fin_cuenta[0*WIDTH +: WIDTH] = 5;
      step(1);
      check("t5 count0 lowered", cnt_of(0), 0);
      check("t5 irq0 lowered", {31'b0, irq[0]}, 1);
      fin_cuenta[0*WIDTH +: WIDTH] = 0;
      step(3);
      check("t5 count0 fin0", cnt_of(0), 0);
      borra_irq[0] = 1'b1;
      step(1);
      check("t5 irq0 set wins", {31'b0, irq[0]}, 1);
      enable[0] = 1'b0;
      step(1);
      check("t5 irq0 cleared", {31'b0, irq[0]}, 0);
      borra_irq[0] = 1'b0;

      // Asynchronous reset mid-run, then restart (prescaled when enabled)
      enable[3] = 1'b1;
      step(3);
`ifdef TIMER_PRESCALER_EN
      presc = 2;
`endif
      rst = 1'b1;
      #1;
      check("t6 rst count", {31'b0, |count}, 0);
      check("t6 rst irq",   {28'b0, irq}, 0);
      check("t6 rst done",  {28'b0, done}, 0);
      enable = 4'b0001;
      mode = '0;
      borra_irq = '0;
      fin_cuenta[0*WIDTH +: WIDTH] = 1;
      step(1);
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step(1);
         check($sformatf("t6 count0 k=%0d", k), cnt_of(0), (k / DIV) % 2);
         check($sformatf("t6 irq0 k=%0d", k), {31'b0, irq[0]}, (k >= 2 * DIV) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
